// File: rtl/pe_ingress.sv
// Network-side ingress for one processing element: buffers PE packets in a
// first-word-fall-through FIFO toward the switch, dropping illegal destinations.
module pe_ingress #(
  parameter int address      = 0,
  parameter int numPE        = 8,
  parameter int AddressWidth = 3,
  parameter int DataWidth    = 32,
  parameter int TotalWidth   = 35,
  parameter int FifoDepth    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [31:0]           o_pkt_count,
  output logic [15:0]           o_drop_count
);

  localparam int PTR_W = $clog2(FifoDepth);
  localparam int OCC_W = $clog2(FifoDepth) + 1;

  // Parameter sanity checks, resolved at elaboration.
  generate
    if (TotalWidth != AddressWidth + DataWidth) begin : g_bad_width
      $error("pe_ingress: TotalWidth must equal AddressWidth + DataWidth");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
      $error("pe_ingress: FifoDepth must be a power of two, at least 2");
    end
    if (address < 0 || address >= numPE) begin : g_bad_address
      $error("pe_ingress: address must identify a legal PE");
    end
  endgenerate

  logic [TotalWidth-1:0] mem [FifoDepth];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [31:0]      pkt_count_reg, pkt_count_next;
  logic [15:0]      drop_count_reg, drop_count_next;

  logic [31:0] dest_ext;
  logic        dest_legal;
  logic        accept;
  logic        push;
  logic        drop;
  logic        pop;

  assign dest_ext   = 32'(i_data[DataWidth +: AddressWidth]);
  assign dest_legal = (dest_ext < 32'(numPE));

  // Ready comes from registered occupancy only, so a full FIFO refuses input
  // even in a cycle where the switch pops.
  assign o_data_ready = (occ_reg != OCC_W'(FifoDepth));
  assign o_data_valid = (occ_reg != '0);
  assign o_data       = mem[rd_ptr_reg];

  assign accept = i_data_valid && o_data_ready;
  assign push   = accept && dest_legal;
  assign drop   = accept && !dest_legal;
  assign pop    = o_data_valid && i_data_ready;

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    occ_next        = occ_reg;
    pkt_count_next  = pkt_count_reg;
    drop_count_next = drop_count_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase

    if (pop && pkt_count_reg != '1) begin
      pkt_count_next = pkt_count_reg + 32'd1;
    end
    if (drop && drop_count_reg != '1) begin
      drop_count_next = drop_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      occ_reg        <= occ_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  assign o_pkt_count  = pkt_count_reg;
  assign o_drop_count = drop_count_reg;

endmodule

// File: tb/tb_pe_ingress.sv
// Directed bench for pe_ingress: a vector table for the cycle-by-cycle cases,
// plus hand-written streaming and asynchronous-reset sequences.
module tb_pe_ingress;

  logic        clk;
  logic        rst;
  logic [34:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [34:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [31:0] o_pkt_count;
  logic [15:0] o_drop_count;

  int checks = 0;
  int errors = 0;

  pe_ingress #(
    .address(0), .numPE(6), .AddressWidth(3), .DataWidth(32),
    .TotalWidth(35), .FifoDepth(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_pkt_count(o_pkt_count), .o_drop_count(o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [34:0] d;
    logic        sr;
    logic        ev;
    logic        er;
    logic        cd;
    logic [34:0] ed;
    logic [31:0] ep;
    logic [15:0] edr;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic v, logic [2:0] dst, logic [31:0] pay, logic sr,
                              logic ev, logic er, logic cd, logic [2:0] edst,
                              logic [31:0] epay, logic [31:0] ep, logic [15:0] edr);
    vec_t r;
    r.v = v; r.d = {dst, pay}; r.sr = sr;
    r.ev = ev; r.er = er; r.cd = cd; r.ed = {edst, epay};
    r.ep = ep; r.edr = edr;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v, dest, payload, sw_ready | valid, ready, check_data, dest, payload, pkt, drop
    vecs[0]  = mk(1, 3'd5, 32'h123, 1,  1, 1, 1, 3'd5, 32'h123, 0, 0);
    vecs[1]  = mk(0, 3'd0, 32'h0,   1,  0, 1, 0, 3'd0, 32'h0,   1, 0);
    vecs[2]  = mk(1, 3'd1, 32'd0,   0,  1, 1, 1, 3'd1, 32'd0,   1, 0);
    vecs[3]  = mk(1, 3'd1, 32'd1,   0,  1, 1, 1, 3'd1, 32'd0,   1, 0);
    vecs[4]  = mk(1, 3'd1, 32'd2,   0,  1, 1, 1, 3'd1, 32'd0,   1, 0);
    vecs[5]  = mk(1, 3'd1, 32'd3,   0,  1, 0, 1, 3'd1, 32'd0,   1, 0);
    vecs[6]  = mk(1, 3'd1, 32'd4,   0,  1, 0, 1, 3'd1, 32'd0,   1, 0);
    vecs[7]  = mk(1, 3'd1, 32'd4,   1,  1, 1, 1, 3'd1, 32'd1,   2, 0);
    vecs[8]  = mk(1, 3'd1, 32'd4,   1,  1, 1, 1, 3'd1, 32'd2,   3, 0);
    vecs[9]  = mk(0, 3'd0, 32'd0,   1,  1, 1, 1, 3'd1, 32'd3,   4, 0);
    vecs[10] = mk(0, 3'd0, 32'd0,   1,  1, 1, 1, 3'd1, 32'd4,   5, 0);
    vecs[11] = mk(0, 3'd0, 32'd0,   1,  0, 1, 0, 3'd0, 32'd0,   6, 0);
    vecs[12] = mk(1, 3'd7, 32'hAA,  1,  0, 1, 0, 3'd0, 32'd0,   6, 1);
    vecs[13] = mk(1, 3'd2, 32'hBB,  1,  1, 1, 1, 3'd2, 32'hBB,  6, 1);
    vecs[14] = mk(0, 3'd0, 32'd0,   1,  0, 1, 0, 3'd0, 32'd0,   7, 1);
    vecs[15] = mk(1, 3'd6, 32'hCC,  1,  0, 1, 0, 3'd0, 32'd0,   7, 2);
    vecs[16] = mk(1, 3'd5, 32'hDD,  1,  1, 1, 1, 3'd5, 32'hDD,  7, 2);
    vecs[17] = mk(0, 3'd0, 32'd0,   1,  0, 1, 0, 3'd0, 32'd0,   8, 2);

    rst = 1'b0;
    i_data = '0;
    i_data_valid = 1'b0;
    i_data_ready = 1'b0;
    #22;
    chk("reset_valid", 64'(o_data_valid), 64'd0);
    chk("reset_ready", 64'(o_data_ready), 64'd1);
    chk("reset_pkt",   64'(o_pkt_count),  64'd0);
    chk("reset_drop",  64'(o_drop_count), 64'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      i_data       = vecs[i].d;
      i_data_valid = vecs[i].v;
      i_data_ready = vecs[i].sr;
      step();
      $display("vec %0d: in v=%0b d=%0h sr=%0b -> valid=%0b ready=%0b data=%0h pkt=%0d drop=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].sr, o_data_valid, o_data_ready,
               o_data, o_pkt_count, o_drop_count);
      chk($sformatf("vec%0d_valid", i), 64'(o_data_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(o_data_ready), 64'(vecs[i].er));
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), 64'(o_data), 64'(vecs[i].ed));
      chk($sformatf("vec%0d_pkt", i),  64'(o_pkt_count),  64'(vecs[i].ep));
      chk($sformatf("vec%0d_drop", i), 64'(o_drop_count), 64'(vecs[i].edr));
    end

    // Streaming: each edge pushes packet k and pops packet k-1, so only k remains.
    i_data_ready = 1'b1;
    i_data_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      i_data = {3'd3, 32'(k)};
      step();
      $display("stream %0d: valid=%0b ready=%0b data=%0h pkt=%0d",
               k, o_data_valid, o_data_ready, o_data, o_pkt_count);
      chk($sformatf("stream%0d_valid", k), 64'(o_data_valid), 64'd1);
      chk($sformatf("stream%0d_ready", k), 64'(o_data_ready), 64'd1);
      chk($sformatf("stream%0d_data", k),  64'(o_data), 64'({3'd3, 32'(k)}));
      chk($sformatf("stream%0d_pkt", k),   64'(o_pkt_count), 64'(8 + k));
    end
    i_data_valid = 1'b0;
    step();
    $display("stream drain: valid=%0b pkt=%0d", o_data_valid, o_pkt_count);
    chk("stream_drain_valid", 64'(o_data_valid), 64'd0);
    chk("stream_pkt_total",   64'(o_pkt_count),  64'd108);

    // Mid-stream reset with three packets buffered.
    i_data_ready = 1'b0;
    i_data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = {3'd4, 32'h300 + 32'(k)};
      step();
    end
    i_data_valid = 1'b0;
    chk("pre_reset_valid", 64'(o_data_valid), 64'd1);
    chk("pre_reset_data",  64'(o_data), 64'({3'd4, 32'h300}));
    #2;
    rst = 1'b0;
    #1;
    $display("async reset: valid=%0b ready=%0b pkt=%0d drop=%0d",
             o_data_valid, o_data_ready, o_pkt_count, o_drop_count);
    chk("async_rst_valid", 64'(o_data_valid), 64'd0);
    chk("async_rst_ready", 64'(o_data_ready), 64'd1);
    chk("async_rst_pkt",   64'(o_pkt_count),  64'd0);
    chk("async_rst_drop",  64'(o_drop_count), 64'd0);
    #2;
    rst = 1'b1;
    i_data = {3'd0, 32'h777};
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
    $display("post reset push: valid=%0b data=%0h", o_data_valid, o_data);
    chk("post_rst_valid", 64'(o_data_valid), 64'd1);
    chk("post_rst_data",  64'(o_data), 64'({3'd0, 32'h777}));
    i_data_ready = 1'b1;
    step();
    $display("post reset pop: valid=%0b pkt=%0d", o_data_valid, o_pkt_count);
    chk("post_rst_empty", 64'(o_data_valid), 64'd0);
    chk("post_rst_pkt",   64'(o_pkt_count),  64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_ingress.md
# pe_ingress

Network-side ingress port paired with each processing element in the HNoC. It accepts packets `{dest, payload}` from a PE over the valid/ready interface and buffers them in a small FIFO. It forwards them to the attached switch input port and applies backpressure to the PE when the FIFO is full. Packets whose destination is outside the PE range are consumed and counted rather than forwarded, and delivered and dropped traffic is exposed as counters.

## Interface
- `address`, 0, index of the attached PE; for identification only, no effect on datapath.
- `numPE`, 8, number of valid destinations; a destination `>= numPE` is illegal.
- `AddressWidth`, 3, width of the destination field.
- `DataWidth`, 32, payload width.
- `TotalWidth`, 35, packet width; must equal `AddressWidth + DataWidth`.
- `FifoDepth`, 4, FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_data`  in  TotalWidth  packet from the PE; `[DataWidth+:AddressWidth]` is the destination, `[DataWidth-1:0]` is the payload.
- `i_data_valid`  in  1  PE presents a packet.
- `o_data_ready`  out  1  ingress can accept a packet this cycle.
- `o_data`  out  TotalWidth  packet to the switch, the FIFO head.
- `o_data_valid`  out  1  FIFO non-empty.
- `i_data_ready`  in  1  switch accepts `o_data` this cycle.
- `o_pkt_count`  out  32  packets forwarded to the switch; saturates at `2^32-1`.
- `o_drop_count`  out  16  packets dropped for an illegal destination; saturates at `0xFFFF`.

## Operation
- **Accept:** an input packet is accepted when `i_data_valid && o_data_ready` at a rising edge.
- **Ready:** `o_data_ready = (occupancy != FifoDepth)`. It depends only on the registered occupancy, never on `i_data_ready`. When the FIFO is full, no packet is accepted, even if a pop happens in the same cycle.
- **Legal accepted packet:** dest `< numPE`. It is written to `mem[wr_ptr]`, `wr_ptr` increments (wrapping modulo `FifoDepth`), and occupancy increments.
- **Illegal accepted packet:** dest `>= numPE`. It is not written; `o_drop_count` increments. This is possible only when `numPE < 2^AddressWidth`.
- **Output:** `o_data = mem[rd_ptr]`, read combinationally (first-word fall-through). `o_data_valid = (occupancy != 0)`.
- **Pop:** when `o_data_valid && i_data_ready`, `rd_ptr` increments with wrap, occupancy decrements, and `o_pkt_count` increments.
- **Simultaneous push and pop** (FIFO not full): occupancy is unchanged and both pointers advance. On an empty FIFO, a push and `i_data_ready` in the same cycle produce no pop, because `o_data_valid` is still 0.
- **Order:** packets leave in arrival order. Payload and destination bits pass through unmodified.
- **Occupancy:** counter of width `$clog2(FifoDepth)+1`, range 0..`FifoDepth`.
- **Counters:** saturating, never wrap. They are cleared only by reset.
- **Reset** (`rst` low, at any time): `wr_ptr`, `rd_ptr`, occupancy and both counters go to 0. The contents of `mem` are not reset.

## Timing
- **Reset values:** `o_data_valid=0`, `o_data_ready=1`, `o_pkt_count=0`, `o_drop_count=0`. `o_data` is don't-care while `o_data_valid=0`.
- **Reset mid-operation:** takes effect immediately, without waiting for a clock edge. All buffered packets are discarded. The first accept is possible at the first rising edge after `rst` is released.
- **Latency:** a packet accepted at edge N into an empty FIFO gives `o_data_valid=1` after edge N. The earliest pop is at edge N+1.
- **Drop count:** `o_drop_count` updates after the accepting edge.
- **Throughput:** one packet per cycle sustained while `i_data_ready=1`.
- **Full FIFO:** `o_data_ready` rises the cycle after the first pop.
- **Handshake rule:** the ingress holds `o_data` and `o_data_valid` stable until `i_data_ready`, and never retracts `o_data_valid`. The PE must hold `i_data` until accepted.

## Test plan
- **Reset:** drive `rst=0`, then release → `o_data_valid=0`, `o_data_ready=1`, both counters 0.
- **Single packet:** `i_data={3'd5,32'h0000_0123}` with `i_data_ready=1` → `o_data` equals the same value one cycle later, `o_pkt_count=1`.
- **Backpressure:** `i_data_ready=0`, push 5 packets with payloads 0..4 and `FifoDepth=4` → `o_data_ready=0` after the 4th; the 5th is held. Then set `i_data_ready=1` → outputs 0,1,2,3,4 in order; `o_pkt_count=5`.
- **Illegal destination:** with `numPE=6`, push dest 7 payload `0xAA` then dest 2 payload `0xBB` → only `0xBB` is forwarded, `o_drop_count=1`, `o_pkt_count=1`.
- **Streaming and wrap-around:** continuous push with `i_data_ready=1` for 100 packets (payloads 0..99) → occupancy stays ≤1, 100 packets arrive in order across pointer wraps, `o_pkt_count=100`.
- **Mid-stream reset:** assert `rst=0` with 3 packets buffered → `o_data_valid` drops to 0 asynchronously, counters clear, and the next accepted packet is the first one forwarded.
